bram_arbiter: RTL and testbench
===============================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 13, BRAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, BRAM data width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, BRAM read latency in cycles (1..3).
REQ-004 The block SHALL have parameter MAX_BURST, default 4, the maximum consecutive grants to one requester while the other waits (>=1).
REQ-005 The block SHALL have these ports:
- sys_clk  in  1  sole clock, rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- req_in[2]  in  1 each  requester n access request.
- we_in[2]  in  1 each  1=write, 0=read.
- addr_in[2]  in  ADDR_W each  address.
- wdata_in[2]  in  DATA_W each  write data.
- gnt_out[2]  out  1 each  access issued this cycle.
- rvalid_out[2]  out  1 each  read data valid.
- rdata_out  out  DATA_W  shared read data.
- en_out, wen_out  out  1  BRAM enable and write enable.
- addr_out  out  ADDR_W  BRAM address.
- wdata_out  out  DATA_W  BRAM write data.
- rdata_in  in  DATA_W  BRAM read data.

Function
REQ-006 Each requester SHALL hold req/we/addr/wdata stable from assertion until the cycle gnt_out is high; one beat transfers per gnt cycle.
REQ-007 gnt_out SHALL be combinational from registered state and current req_in; at most one gnt_out SHALL be high per cycle.
REQ-008 In a gnt cycle the BRAM port SHALL carry the winner's signals: en_out=1, wen_out=we_in, addr_out, wdata_out; with no grant, en_out=0, wen_out=0, and addr/wdata hold their last values.
REQ-009 The FSM SHALL have states IDLE, OWN0 and OWN1.
- IDLE: a single requester wins; if both request, the requester not equal to last_owner wins.
- OWNn: n keeps the grant while req_in[n]=1 and either the other is idle or burst_cnt<MAX_BURST-1.
- Otherwise a requesting other side wins, or the FSM goes to IDLE if none requests.
REQ-010 burst_cnt SHALL count consecutive grants to the current owner: it clears on an owner change or on IDLE, increments on each retained grant, and saturates at MAX_BURST-1.
REQ-011 last_owner SHALL update to the granted requester on every grant.
REQ-012 For a granted read, rvalid_out[n] SHALL pulse exactly RD_LAT cycles after the gnt cycle, with rdata_out=rdata_in; this is a fully pipelined RD_LAT-deep owner/valid shift register.
REQ-013 Writes SHALL produce no rvalid.
REQ-014 Back-to-back reads from alternating requesters SHALL each return to the correct requester with no bubble.
REQ-015 MAX_BURST=1 SHALL give strict alternation under continuous contention.

Reset
REQ-016 While sys_rst=1, gnt_out, rvalid_out, en_out and wen_out SHALL be 0; addr_out, wdata_out and rdata_out SHALL be 0; state=IDLE; burst_cnt=0; last_owner=1, so requester 0 wins the first tie.
REQ-017 Reads in flight at reset SHALL be discarded, with no rvalid after reset release.
REQ-018 Grants SHALL resume in the first cycle after sys_rst deasserts.

Configuration
REQ-019 With BRAM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win contention: the round-robin and burst limit are bypassed, and requester 1 is granted only when req_in[0]=0.
REQ-020 Without BRAM_ARB_FIXED_PRIO_EN, the round-robin/burst behaviour of REQ-009 and REQ-010 SHALL apply.

Structure
REQ-021 Package bram_arb_pkg SHALL hold the FSM state enum (IDLE, OWN0, OWN1), the requester-id typedef, and default ADDR_W/DATA_W constants shared with spi_slave_to_bram.
REQ-022 The read-return pipeline SHALL be sub-module bram_arb_rd_pipe (RD_LAT-deep valid/owner shift register).

Verification
REQ-023 Single read: req0 reads addr 0x0010, which holds 0xA5 -> gnt0 same cycle, rvalid0=1 and rdata_out=0xA5 RD_LAT cycles later, rvalid1 stays 0.
REQ-024 Contention: after reset both request continuously with MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0...
REQ-025 Write/readback: req1 writes 0x5A to 0x1FFF, then req0 reads 0x1FFF -> rvalid0 with 0x5A; no rvalid for the write.
REQ-026 Alternating reads with MAX_BURST=1 and RD_LAT=2: addresses 0x0001 and 0x0002 -> rvalid alternates 0,1 each cycle with the correct data and no bubble.
REQ-027 Reset mid-read: assert sys_rst one cycle after a read gnt -> no rvalid at any time; the first post-reset tie goes to requester 0.
REQ-028 With BRAM_ARB_FIXED_PRIO_EN and both requesting for 10 cycles -> gnt0 high for all 10 cycles; gnt1 is first high the cycle after req0 drops.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester BRAM arbiter.
// Holds FSM states, requester id type and default BRAM widths.
package bram_arb_pkg;

  localparam int BRAM_ADDR_W = 13;
  localparam int BRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } arb_state_t;

  typedef logic req_id_t;

  function automatic arb_state_t own_state(req_id_t id);
    return id ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/bram_arb_rd_pipe.sv
// Read-return pipeline: RD_LAT-deep valid/owner shift register.
// Ports: clk, rst, vld_in, own_in in; rvalid_out[1:0] out.
module bram_arb_rd_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_in,
  input  req_id_t    own_in,
  output logic [1:0] rvalid_out
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_q, own_d;

  always_comb begin
    vld_d    = vld_q;
    own_d    = own_q;
    vld_d[0] = vld_in;
    own_d[0] = own_in;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= vld_d;
      own_q <= own_d;
    end
  end

  assign rvalid_out[0] = vld_q[RD_LAT-1] & ~own_q[RD_LAT-1];
  assign rvalid_out[1] = vld_q[RD_LAT-1] &  own_q[RD_LAT-1];

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester single-port BRAM arbiter, round-robin with burst limit.
// Ports: sys_clk/sys_rst; req/we/addr/wdata per requester; gnt/rvalid
// per requester; shared rdata_out; BRAM en/wen/addr/wdata/rdata.
// Option: BRAM_ARB_FIXED_PRIO_EN makes requester 0 always win.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W    = BRAM_ADDR_W,
  parameter int DATA_W    = BRAM_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [1:0]        req_in,
  input  logic [1:0]        we_in,
  input  logic [ADDR_W-1:0] addr_in [2],
  input  logic [DATA_W-1:0] wdata_in [2],
  output logic [1:0]        gnt_out,
  output logic [1:0]        rvalid_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              en_out,
  output logic              wen_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] wdata_out,
  input  logic [DATA_W-1:0] rdata_in
);

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_TOP = BW'(MAX_BURST - 1);

  arb_state_t        state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  req_id_t           last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic    grant;
  req_id_t win;
  req_id_t owner;
  req_id_t oth;

  assign owner = (state_q == OWN1);

  always_comb begin
    grant = 1'b0;
    win   = 1'b0;
    oth   = ~owner;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    grant = |req_in;
    win   = ~req_in[0];
`else
    unique case (state_q)
      IDLE: begin
        if (&req_in) begin
          grant = 1'b1;
          win   = ~last_q;
        end else if (|req_in) begin
          grant = 1'b1;
          win   = req_in[1];
        end
      end
      default: begin
        if (req_in[owner] &&
            (!req_in[oth] || burst_q < BURST_TOP)) begin
          grant = 1'b1;
          win   = owner;
        end else if (req_in[oth]) begin
          grant = 1'b1;
          win   = oth;
        end
      end
    endcase
`endif
    // Nothing may be issued while reset is held.
    if (sys_rst) grant = 1'b0;
  end

  always_comb begin
    state_d = grant ? own_state(win) : IDLE;
    burst_d = '0;
    if (grant && state_q != IDLE && win == owner)
      burst_d = (burst_q == BURST_TOP) ? burst_q : burst_q + BW'(1);
    last_d  = grant ? win : last_q;
    addr_d  = grant ? addr_in[win] : addr_q;
    wdata_d = grant ? wdata_in[win] : wdata_q;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt_out   = {grant & win, grant & ~win};
  assign en_out    = grant;
  assign wen_out   = grant & we_in[win];
  assign addr_out  = addr_d;
  assign wdata_out = wdata_d;

  bram_arb_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .vld_in    (grant & ~we_in[win]),
    .own_in    (win),
    .rvalid_out(rvalid_out)
  );

  assign rdata_out = (|rvalid_out) ? rdata_in : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: instance a (RD_LAT=1, MAX_BURST=4)
// and instance b (RD_LAT=2, MAX_BURST=1) share one stimulus stream.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we;
  logic [12:0] addr [2];
  logic [7:0]  wd [2];

  logic [1:0]  gnt_a, rv_a, gnt_b, rv_b;
  logic [7:0]  rd_a, rd_b, wdo_a, wdo_b, rdi_a, rdi_b;
  logic        en_a, wen_a, en_b, wen_b;
  logic [12:0] ao_a, ao_b;

  logic [7:0]  mem_a [8192];
  logic [7:0]  mem_b [8192];
  logic [7:0]  ra0, rb0, rb1;

  int n_chk = 0;
  int n_fail = 0;

  logic [1:0] ga_exp [10];
  logic [1:0] gb_exp [10];

  always #5 clk = ~clk;

  bram_arbiter #(
    .ADDR_W(13), .DATA_W(8), .RD_LAT(1), .MAX_BURST(4)
  ) u_dut_a (
    .sys_clk(clk), .sys_rst(rst),
    .req_in(req), .we_in(we), .addr_in(addr), .wdata_in(wd),
    .gnt_out(gnt_a), .rvalid_out(rv_a), .rdata_out(rd_a),
    .en_out(en_a), .wen_out(wen_a), .addr_out(ao_a),
    .wdata_out(wdo_a), .rdata_in(rdi_a)
  );

  bram_arbiter #(
    .ADDR_W(13), .DATA_W(8), .RD_LAT(2), .MAX_BURST(1)
  ) u_dut_b (
    .sys_clk(clk), .sys_rst(rst),
    .req_in(req), .we_in(we), .addr_in(addr), .wdata_in(wd),
    .gnt_out(gnt_b), .rvalid_out(rv_b), .rdata_out(rd_b),
    .en_out(en_b), .wen_out(wen_b), .addr_out(ao_b),
    .wdata_out(wdo_b), .rdata_in(rdi_b)
  );

  // Simple BRAM models, latency 1 (a) and 2 (b).
  always @(posedge clk) begin
    if (rst) begin
      mem_a[16] <= 8'hA5; mem_a[1] <= 8'h11; mem_a[2] <= 8'h22;
      mem_b[16] <= 8'hA5; mem_b[1] <= 8'h11; mem_b[2] <= 8'h22;
    end
    if (en_a) begin
      if (wen_a) mem_a[ao_a] <= wdo_a;
      else ra0 <= mem_a[ao_a];
    end
    if (en_b) begin
      if (wen_b) mem_b[ao_b] <= wdo_b;
      else rb0 <= mem_b[ao_b];
    end
    rb1 <= rb0;
  end

  assign rdi_a = ra0;
  assign rdi_b = rb1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
    ga_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
               2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    gb_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
               2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`else
    ga_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
               2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
    gb_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01,
               2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    rst = 1'b1;
    req = 2'b11;
    we = 2'b00;
    addr[0] = '0; addr[1] = '0;
    wd[0] = '0; wd[1] = '0;
    repeat (3) tick();

    // Reset state, with requests held high
    @(negedge clk);
    check("rst_gnt", gnt_a, 2'b00);
    check("rst_rv", rv_a, 2'b00);
    check("rst_en", en_a, 1'b0);
    check("rst_wen", wen_a, 1'b0);
    check("rst_addr", ao_a, 13'h0);
    check("rst_wdata", wdo_a, 8'h0);
    check("rst_rdata", rd_a, 8'h0);

    // Single read of 0x0010 by requester 0
    tick();
    rst = 1'b0;
    req = 2'b01;
    addr[0] = 13'h0010;
    @(negedge clk);
    check("rd_gnt_a", gnt_a, 2'b01);
    check("rd_gnt_b", gnt_b, 2'b01);
    check("rd_en", en_a, 1'b1);
    check("rd_wen", wen_a, 1'b0);
    check("rd_addr", ao_a, 13'h0010);
    tick();
    req = 2'b00;
    @(negedge clk);
    check("rd_rv_a", rv_a, 2'b01);
    check("rd_data_a", rd_a, 8'hA5);
    check("rd_idle_en", en_a, 1'b0);
    check("rd_addr_hold", ao_a, 13'h0010);
    check("rd_rv_b_early", rv_b, 2'b00);
    tick();
    @(negedge clk);
    check("rd_rv_b", rv_b, 2'b01);
    check("rd_data_b", rd_b, 8'hA5);
    check("rd_rv_a_once", rv_a, 2'b00);

    // Write 0x5A to 0x1FFF by req1, read back by req0
    tick();
    req = 2'b10;
    we = 2'b10;
    addr[1] = 13'h1FFF;
    wd[1] = 8'h5A;
    @(negedge clk);
    check("wr_gnt", gnt_a, 2'b10);
    check("wr_wen", wen_a, 1'b1);
    check("wr_addr", ao_a, 13'h1FFF);
    check("wr_wdata", wdo_a, 8'h5A);
    tick();
    req = 2'b01;
    we = 2'b00;
    addr[0] = 13'h1FFF;
    @(negedge clk);
    check("wb_gnt", gnt_a, 2'b01);
    check("wr_no_rv", rv_a, 2'b00);
    tick();
    req = 2'b00;
    @(negedge clk);
    check("wb_rv", rv_a, 2'b01);
    check("wb_data", rd_a, 8'h5A);

    // Continuous contention after reset, reads of 0x0001 / 0x0002
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 2'b11;
    addr[0] = 13'h0001;
    addr[1] = 13'h0002;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("cont_gnt_a%0d", k), gnt_a, ga_exp[k]);
      check($sformatf("cont_gnt_b%0d", k), gnt_b, gb_exp[k]);
      if (k >= 1) begin
        check($sformatf("cont_rv_a%0d", k), rv_a, ga_exp[k-1]);
        check($sformatf("cont_rd_a%0d", k), rd_a,
              (ga_exp[k-1] == 2'b01) ? 8'h11 : 8'h22);
      end
      if (k >= 2) begin
        check($sformatf("cont_rv_b%0d", k), rv_b, gb_exp[k-2]);
        check($sformatf("cont_rd_b%0d", k), rd_b,
              (gb_exp[k-2] == 2'b01) ? 8'h11 : 8'h22);
      end
      tick();
    end
    req = 2'b00;
    repeat (3) tick();

    // Reset one cycle after a read grant
    req = 2'b01;
    addr[0] = 13'h0010;
    @(negedge clk);
    check("mr_gnt", gnt_a, 2'b01);
    tick();
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    check("mr_rv_a0", rv_a, 2'b00);
    check("mr_rv_b0", rv_b, 2'b00);
    tick();
    @(negedge clk);
    check("mr_rv_b1", rv_b, 2'b00);
    tick();
    rst = 1'b0;
    req = 2'b11;
    @(negedge clk);
    check("mr_tie_a", gnt_a, 2'b01);
    check("mr_tie_b", gnt_b, 2'b01);
    check("mr_rv_a2", rv_a, 2'b00);
    check("mr_rv_b2", rv_b, 2'b00);
    tick();
    req = 2'b00;
    repeat (3) tick();

`ifdef BRAM_ARB_FIXED_PRIO_EN
    req = 2'b11;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("fp_gnt%0d", k), gnt_a, 2'b01);
      tick();
    end
    req = 2'b10;
    @(negedge clk);
    check("fp_gnt1", gnt_a, 2'b10);
    tick();
    req = 2'b00;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
